// File: rtl/tt_um_taghreed_eialsalman_logic_unit.sv
// ---------------------------------------------------------------------------
// tt_um_taghreed_eialsalman_logic_unit
//
// Registered bitwise logic unit (8 two-input ops on WIDTH-bit A/B) with a
// self-running truth-table sweep. In sweep mode an FSM walks every A/B
// combination using the op latched at start. When SWEEP_SIG_EN is defined,
// the results are also folded into a 4-bit rotate-xor signature.
//
// Optional feature macro: SWEEP_SIG_EN (builds the signature register and
// drives it on uio_out[7:4]).
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   ena      design enable; 0 holds every register
//   ui_in    [3:0]=A, [7:4]=B (low WIDTH bits used)
//   uio_in   [2:0]=op, [3]=start (asynchronous pin), [7:4] unused
//   uo_out   [3:0]=Y, [4]=busy, [5]=done, [6]=|Y, [7]=^Y
//   uio_out  [7:4]=signature (SWEEP_SIG_EN), otherwise 0
//   uio_oe   8'hF0 with SWEEP_SIG_EN, otherwise 8'h00
// ---------------------------------------------------------------------------
module tt_um_taghreed_eialsalman_logic_unit #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    logic_op = ~(a & b);
      3'd1:    logic_op = a & b;
      3'd2:    logic_op = a | b;
      3'd3:    logic_op = ~(a | b);
      3'd4:    logic_op = a ^ b;
      3'd5:    logic_op = ~(a ^ b);
      3'd6:    logic_op = ~a;
      default: logic_op = a;
    endcase
  endfunction

  function automatic logic [3:0] zext4(input logic [WIDTH-1:0] v);
    logic [3:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sync3_q, sync3_d;
  logic             start_p_q, start_p_d;
  logic [WIDTH-1:0] sweep_y;
`ifdef SWEEP_SIG_EN
  logic [3:0]       sig_q, sig_d;
`endif

  // Operand/op pins not consumed at this WIDTH are collected here.
  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in, uio_in};

  // In sweep mode the counter itself supplies the operands: A is the low
  // half, B the high half, so A varies fastest.
  assign sweep_y = logic_op(op_q, cnt_q[WIDTH-1:0], cnt_q[CW-1:WIDTH]);

  always_comb begin
    // start pin: two synchroniser flops, a history flop, and a registered
    // rising-edge pulse that the FSM consumes one cycle later.
    sync1_d   = uio_in[3];
    sync2_d   = sync1_q;
    sync3_d   = sync2_q;
    start_p_d = sync2_q & ~sync3_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef SWEEP_SIG_EN
    sig_d   = sig_q;
`endif

    case (state_q)
      ST_IDLE: begin
        y_d = logic_op(uio_in[2:0], ui_in[WIDTH-1:0], ui_in[4+WIDTH-1:4]);
        if (start_p_q) begin
          state_d = ST_SWEEP;
          op_d    = uio_in[2:0];
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef SWEEP_SIG_EN
          sig_d   = '0;
`endif
        end
      end
      ST_SWEEP: begin
        y_d = sweep_y;
`ifdef SWEEP_SIG_EN
        sig_d = {sig_q[2:0], sig_q[3]} ^ zext4(sweep_y);
`endif
        // The counter parks on the last vector instead of wrapping; it is
        // cleared on the way back to IDLE.
        if (cnt_q == {CW{1'b1}}) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      y_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      start_p_q <= 1'b0;
`ifdef SWEEP_SIG_EN
      sig_q     <= '0;
`endif
    end else if (ena) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      y_q       <= y_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
      start_p_q <= start_p_d;
`ifdef SWEEP_SIG_EN
      sig_q     <= sig_d;
`endif
    end
  end

  assign uo_out = {^y_q, |y_q, done_q, busy_q, zext4(y_q)};

`ifdef SWEEP_SIG_EN
  assign uio_out = {sig_q, 4'h0};
  assign uio_oe  = 8'hF0;
`else
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_taghreed_eialsalman_logic_unit.sv
// Bench for tt_um_taghreed_eialsalman_logic_unit: a WIDTH=4 and a WIDTH=1
// instance share clock, reset and enable but have independent pins.
module tb_tt_um_taghreed_eialsalman_logic_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena;
  logic [7:0] ui4, uio4, uo4, uioo4, oe4;
  logic [7:0] ui1, uio1, uo1, uioo1, oe1;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SWEEP_SIG_EN
  localparam logic [7:0] OE_EXP = 8'hF0;
`else
  localparam logic [7:0] OE_EXP = 8'h00;
`endif

  tt_um_taghreed_eialsalman_logic_unit #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui4), .uio_in(uio4),
    .uo_out(uo4), .uio_out(uioo4), .uio_oe(oe4));

  tt_um_taghreed_eialsalman_logic_unit #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui1), .uio_in(uio1),
    .uo_out(uo1), .uio_out(uioo1), .uio_oe(oe1));

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
  } vec_t;

  vec_t tbl[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the eight ops straight from their definitions, masked to w bits.
  function automatic logic [3:0] ref_f(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input int w);
    logic [3:0] r;
    logic [3:0] m;
    m = 4'((1 << w) - 1);
    case (op)
      3'd0:    r = ~(a & b);
      3'd1:    r = a & b;
      3'd2:    r = a | b;
      3'd3:    r = ~(a | b);
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~a;
      default: r = a;
    endcase
    return r & m;
  endfunction

  // Signature over the whole truth table, A varying fastest.
  function automatic logic [3:0] model_sig(input logic [2:0] op, input int w);
    logic [3:0] s;
    s = 4'h0;
    for (int c = 0; c < (1 << (2 * w)); c++)
      s = {s[2:0], s[3]} ^ ref_f(op, 4'(c % (1 << w)), 4'(c >> w), w);
    return s;
  endfunction

  task automatic check_sig(input string name, input logic [7:0] uo, input logic [3:0] s);
`ifdef SWEEP_SIG_EN
    check(name, int'(uo[7:4]), int'(s));
`else
    check(name, int'(uo), 0);
`endif
  endtask

  // Full sweep on the WIDTH=4 instance. Optional ena gap and a mid-sweep
  // start re-toggle; start stays high after the sweep to show no restart.
  task automatic sweep4(input logic [2:0] op, input int gap_at, input int gap_len,
                        input bit toggle);
    int lat, busy_cnt, v, t, y_bad;
    bit en_v;
    uio4 = {4'h0, 1'b1, op};
    ui4  = 8'($urandom);
    lat  = 0;
    do begin tick(); lat++; end while (!uo4[4] && lat < 12);
    check($sformatf("sweep op%0d start latency", op), lat, 4);
    uio4 = {4'h0, 1'b1, op ^ 3'd5};
    ui4  = 8'($urandom);
    busy_cnt = 1; v = 0; t = 0; y_bad = 0;
    while (uo4[4] && t < 700) begin
      en_v = !(t >= gap_at && t < gap_at + gap_len);
      ena  = en_v;
      if (toggle && t == 50) uio4[3] = 1'b0;
      if (toggle && t == 60) uio4[3] = 1'b1;
      tick();
      if (en_v) begin
        if (uo4[3:0] !== ref_f(op, 4'(v % 16), 4'(v / 16), 4)) y_bad++;
        v++;
      end
      if (uo4[4]) busy_cnt++;
      t++;
    end
    ena = 1'b1;
    check($sformatf("sweep op%0d Y errors", op), y_bad, 0);
    check($sformatf("sweep op%0d vectors", op), v, 256);
    check($sformatf("sweep op%0d busy cycles", op), busy_cnt, 256 + gap_len);
    check($sformatf("sweep op%0d done set", op), int'(uo4[5]), 1);
    check_sig($sformatf("sweep op%0d sig", op), uioo4, model_sig(op, 4));
    tick();
    check($sformatf("sweep op%0d done cleared", op), int'(uo4[5:4]), 0);
    lat = 0;
    repeat (8) begin
      uio4[2:0] = 3'($urandom);
      ui4 = 8'($urandom);
      tick();
      if (uo4[4] || uo4[5]) lat++;
    end
    check($sformatf("sweep op%0d no restart", op), lat, 0);
    check_sig($sformatf("sweep op%0d sig retained", op), uioo4, model_sig(op, 4));
    uio4 = 8'h00;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op, op1;
    logic [3:0] y1_exp[4];
    int cnt;

    tbl[0] = '{3'd0, 4'hF, 4'h3, 4'hC};
    tbl[1] = '{3'd0, 4'hA, 4'hC, 4'h7};
    tbl[2] = '{3'd1, 4'hA, 4'hC, 4'h8};
    tbl[3] = '{3'd2, 4'hA, 4'hC, 4'hE};
    tbl[4] = '{3'd3, 4'hA, 4'hC, 4'h1};
    tbl[5] = '{3'd4, 4'hA, 4'hC, 4'h6};
    tbl[6] = '{3'd5, 4'hA, 4'hC, 4'h9};
    tbl[7] = '{3'd6, 4'hA, 4'hC, 4'h5};
    tbl[8] = '{3'd7, 4'hA, 4'hC, 4'hA};
    y1_exp[0] = 4'h1; y1_exp[1] = 4'h1; y1_exp[2] = 4'h1; y1_exp[3] = 4'h0;

    rst_n = 1'b0; ena = 1'b1;
    ui4 = 8'hFF; uio4 = 8'h07; ui1 = 8'hFF; uio1 = 8'h07;
    tick(); tick();
    check("reset uo_out w4", int'(uo4), 0);
    check("reset uio_out w4", int'(uioo4), 0);
    check("uio_oe w4", int'(oe4), int'(OE_EXP));
    check("reset uo_out w1", int'(uo1), 0);
    check("uio_oe w1", int'(oe1), int'(OE_EXP));
    uio4 = 8'h00; uio1 = 8'h00;
    rst_n = 1'b1;
    tick();

    // Directed op table on the WIDTH=4 instance.
    for (int i = 0; i < 9; i++) begin
      ui4  = {tbl[i].b, tbl[i].a};
      uio4 = {5'b0, tbl[i].op};
      tick();
      check($sformatf("tbl[%0d] Y", i), int'(uo4[3:0]), int'(tbl[i].y));
      check($sformatf("tbl[%0d] or/xor", i), int'(uo4[7:6]),
            int'({^tbl[i].y, |tbl[i].y}));
    end

    // Random IDLE traffic on both instances.
    for (int i = 0; i < 40; i++) begin
      op   = 3'($urandom);
      op1  = 3'($urandom);
      ui4  = 8'($urandom);
      ui1  = 8'($urandom);
      uio4 = {4'($urandom), 1'b0, op};
      uio1 = {4'($urandom), 1'b0, op1};
      tick();
      check($sformatf("rnd[%0d] w4 Y", i), int'(uo4[3:0]), int'(ref_f(op, ui4[3:0], ui4[7:4], 4)));
      check($sformatf("rnd[%0d] w4 flags", i), int'(uo4[7:4]),
            int'({^ref_f(op, ui4[3:0], ui4[7:4], 4), |ref_f(op, ui4[3:0], ui4[7:4], 4), 2'b00}));
      check($sformatf("rnd[%0d] w1 Y", i), int'(uo1[3:0]),
            int'(ref_f(op1, {3'b0, ui1[0]}, {3'b0, ui1[4]}, 1)));
    end
    uio4 = 8'h00; uio1 = 8'h00;
    tick();

    // WIDTH=1 NAND sweep with a two-cycle start pulse.
    uio1 = 8'h08; ui1 = 8'h00;
    tick(); tick();
    uio1 = 8'h00;
    tick();
    check("w1 busy not yet", int'(uo1[4]), 0);
    tick();
    check("w1 busy after start", int'(uo1[4]), 1);
    cnt = 1;
    for (int i = 0; i < 4; i++) begin
      uio1 = {5'b0, 3'($urandom)};
      tick();
      check($sformatf("w1 sweep Y[%0d]", i), int'(uo1[3:0]), int'(y1_exp[i]));
      if (uo1[4]) cnt++;
    end
    check("w1 busy cycles", cnt, 4);
    check("w1 done", int'(uo1[5]), 1);
    check_sig("w1 sig", uioo1, 4'hE);
    tick();
    check("w1 done cleared", int'(uo1[5]), 0);
    uio1 = 8'h00;

    // WIDTH=4 sweeps: plain, and with ena gap plus mid-sweep start re-edge.
    sweep4(3'd4, -1, 0, 1'b0);
    sweep4(3'd1, 100, 10, 1'b1);

    // Reset in the middle of a sweep.
    uio4 = 8'h0A;
    cnt = 0;
    do begin tick(); cnt++; end while (!uo4[4] && cnt < 12);
    check("rst-sweep started", int'(uo4[4]), 1);
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    check("mid-sweep reset uo_out", int'(uo4), 0);
    check("mid-sweep reset uio_out", int'(uioo4), 0);
    uio4 = 8'h00;
    tick();
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin tick(); if (uo4[5] || uo4[4]) cnt++; end
    check("after reset no busy/done", cnt, 0);
    ui4 = 8'h5C; uio4 = 8'h01;
    tick();
    check("after reset IDLE Y", int'(uo4[3:0]), int'(ref_f(3'd1, 4'hC, 4'h5, 4)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
